// File: rtl/contador_modn_cascata.sv
// Multi-digit mod-N cascade counter for timer displays (e.g. mm:ss, hh:mm).
// Each digit is its own mod-N stage. The stages are chained through
// carry/borrow terms. The counter supports up/down counting, wrap or
// saturate at the end, a sticky done flag and clamped parallel load.

// One digit of the cascade: a mod-MOD up/down stage with clamped load.
module contador_modn_digito #(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       loadn,
  input  logic [3:0] data,
  input  logic       step,
  input  logic       up,
  output logic [3:0] d,
  output logic       term
);

  localparam logic [3:0] MAXV = MOD - 4'd1;

  logic [3:0] load_val;
  logic [3:0] nxt;

  // Out-of-range load values saturate to the largest legal digit.
  always_comb begin
    load_val = (data > MAXV) ? MAXV : data;
  end

  // Next value for one step in the current direction, wrapping inside the modulus.
  always_comb begin
    nxt = d;
    if (up) nxt = (d == MAXV) ? 4'd0 : d + 4'd1;
    else    nxt = (d == 4'd0) ? MAXV : d - 4'd1;
  end

  // The terminal value depends on direction: MOD-1 when counting up, 0 when counting down.
  always_comb begin
    term = up ? (d == MAXV) : (d == 4'd0);
  end

  // Digit register. Clear has priority over load, and load over step.
  always_ff @(posedge clk) begin
    if (!clearn)     d <= 4'd0;
    else if (!loadn) d <= load_val;
    else if (step)   d <= nxt;
  end

endmodule

// Cascade top: builds the carry chain and owns the done flag.
module contador_modn_cascata #(
  parameter int                  NDIG = 4,
  parameter logic [4*NDIG-1:0]   MODS = 16'h6A6A
) (
  input  logic              clk,
  input  logic              clearn,
  input  logic              loadn,
  input  logic [4*NDIG-1:0] data,
  input  logic              en,
  input  logic              up,
  input  logic              stop_at_end,
  output logic [4*NDIG-1:0] count,
  output logic              zero,
  output logic              tc,
  output logic              done,
  output logic [NDIG-1:0]   dig_tc
);

  logic [NDIG-1:0][3:0] cnt;
  logic [NDIG-1:0][3:0] din;
  logic [NDIG-1:0]      term;
  logic [NDIG-1:0]      step;
  logic                 all_term;
  logic                 hold;
  logic                 adv;

  assign din      = data;
  assign count    = cnt;
  assign all_term = &term;
  // Saturate: stay at the terminal state instead of wrapping.
  assign hold     = en & all_term & stop_at_end;
  assign adv      = en & ~hold;
  assign zero     = (count == '0);
  assign tc       = dig_tc[NDIG-1];

  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_dig
      if (i == 0) begin : g_lsd
        assign dig_tc[i] = en & term[i];
        assign step[i]   = adv;
      end else begin : g_upper
        // A higher digit moves only when every lower digit is at its terminal value.
        assign dig_tc[i] = dig_tc[i-1] & term[i];
        assign step[i]   = adv & dig_tc[i-1];
      end

      contador_modn_digito #(.MOD(MODS[4*i +: 4])) u_dig (
        .clk    (clk),
        .clearn (clearn),
        .loadn  (loadn),
        .data   (din[i]),
        .step   (step[i]),
        .up     (up),
        .d      (cnt[i]),
        .term   (term[i])
      );
    end
  endgenerate

  // done is set while saturated. It clears on clear, on load, or when the counter moves.
  // Digit 0 steps on every enabled non-hold cycle, so every advance changes the count.
  always_ff @(posedge clk) begin
    if (!clearn)     done <= 1'b0;
    else if (!loadn) done <= 1'b0;
    else if (hold)   done <= 1'b1;
    else if (en)     done <= 1'b0;
  end

endmodule

// File: tb/tb_contador_modn_cascata.sv
// Directed test of the default mm:ss cascade (digit modulus 10,6,10,6).
module tb_contador_modn_cascata;

  logic        clk = 1'b0;
  logic        clearn, loadn, en, up, stop_at_end;
  logic [15:0] data;
  logic [15:0] count;
  logic        zero, tc, done;
  logic [3:0]  dig_tc;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  contador_modn_cascata #(.NDIG(4), .MODS(16'h6A6A)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .loadn       (loadn),
    .data        (data),
    .en          (en),
    .up          (up),
    .stop_at_end (stop_at_end),
    .count       (count),
    .zero        (zero),
    .tc          (tc),
    .done        (done),
    .dig_tc      (dig_tc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    en = 1'b0; loadn = 1'b0; data = v;
    tick();
    loadn = 1'b1;
  endtask

  task automatic test_reset();
    clearn = 1'b0; loadn = 1'b0; en = 1'b1; up = 1'b1; stop_at_end = 1'b0;
    data = 16'h1234;
    tick();
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h exp 0000", count); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b exp 1", zero); end
    n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_up got %b exp 0", tc); end
    clearn = 1'b1; loadn = 1'b1; en = 1'b0; up = 1'b0;
    #1;
    n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL tc_en0 got %b exp 0", tc); end
  endtask

  task automatic test_load_down();
    do_load(16'h0100);
    en = 1'b1; up = 1'b0; stop_at_end = 1'b0;
    #1;
    n_chk++; if (count !== 16'h0100) begin n_fail++; $display("FAIL load_0100 got %h exp 0100", count); end
    n_chk++; if (dig_tc !== 4'b0011) begin n_fail++; $display("FAIL dig_tc_0100 got %b exp 0011", dig_tc); end
    n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL tc_0100 got %b exp 0", tc); end
    tick();
    n_chk++; if (count !== 16'h0059) begin n_fail++; $display("FAIL down_1 got %h exp 0059", count); end
    tick();
    n_chk++; if (count !== 16'h0058) begin n_fail++; $display("FAIL down_2 got %h exp 0058", count); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL down_done got %b exp 0", done); end
  endtask

  task automatic test_wrap_down();
    en = 1'b0; clearn = 1'b0;
    tick();
    clearn = 1'b1; en = 1'b1; up = 1'b0; stop_at_end = 1'b0;
    #1;
    n_chk++; if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_tc got %b exp 1", tc); end
    n_chk++; if (dig_tc !== 4'b1111) begin n_fail++; $display("FAIL wrap_dig_tc got %b exp 1111", dig_tc); end
    tick();
    n_chk++; if (count !== 16'h5959) begin n_fail++; $display("FAIL wrap_down got %h exp 5959", count); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL wrap_done got %b exp 0", done); end
    n_chk++; if (zero !== 1'b0) begin n_fail++; $display("FAIL wrap_zero got %b exp 0", zero); end
  endtask

  task automatic test_stop_at_end();
    do_load(16'h0001);
    en = 1'b1; up = 1'b0; stop_at_end = 1'b1;
    tick();
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL sae_reach got %h exp 0000", count); end
    n_chk++; if (tc !== 1'b1) begin n_fail++; $display("FAIL sae_tc got %b exp 1", tc); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL sae_done_early got %b exp 0", done); end
    tick();
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL sae_hold got %h exp 0000", count); end
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL sae_done got %b exp 1", done); end
    tick();
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL sae_sticky got %b exp 1", done); end
    stop_at_end = 1'b0;
    tick();
    n_chk++; if (count !== 16'h5959) begin n_fail++; $display("FAIL sae_drop got %h exp 5959", count); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL sae_drop_done got %b exp 0", done); end
  endtask

  task automatic test_up_wrap_hold();
    do_load(16'h5958);
    en = 1'b1; up = 1'b1; stop_at_end = 1'b0;
    #1;
    n_chk++; if (dig_tc !== 4'b0000) begin n_fail++; $display("FAIL up_dig_tc_5958 got %b exp 0000", dig_tc); end
    tick();
    n_chk++; if (count !== 16'h5959) begin n_fail++; $display("FAIL up_1 got %h exp 5959", count); end
    n_chk++; if (tc !== 1'b1) begin n_fail++; $display("FAIL up_tc got %b exp 1", tc); end
    n_chk++; if (dig_tc !== 4'b1111) begin n_fail++; $display("FAIL up_dig_tc got %b exp 1111", dig_tc); end
    tick();
    n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL up_wrap got %h exp 0000", count); end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (count !== 16'h0000) begin n_fail++; $display("FAIL en0_hold[%0d] got %h exp 0000", k, count); end
    end
    n_chk++; if (tc !== 1'b0) begin n_fail++; $display("FAIL en0_tc got %b exp 0", tc); end
    up = 1'b0;
    #1;
    n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL en0_zero got %b exp 1", zero); end
  endtask

  task automatic test_load_clamp();
    // Get into the saturated state first, so the test also shows that load clears done.
    do_load(16'h0000);
    en = 1'b1; up = 1'b0; stop_at_end = 1'b1;
    tick();
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL clamp_pre_done got %b exp 1", done); end
    en = 1'b0; loadn = 1'b0; data = 16'hFFC7;
    tick();
    n_chk++; if (count !== 16'h5957) begin n_fail++; $display("FAIL clamp got %h exp 5957", count); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL clamp_done got %b exp 0", done); end
    data = 16'h0000;
    tick();
    en = 1'b1; up = 1'b1; stop_at_end = 1'b0; data = 16'hFFC7;
    tick();
    n_chk++; if (count !== 16'h5957) begin n_fail++; $display("FAIL clamp_en got %h exp 5957", count); end
    loadn = 1'b1;
    tick();
    n_chk++; if (count !== 16'h5958) begin n_fail++; $display("FAIL after_load_up got %h exp 5958", count); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_down();
    test_wrap_down();
    test_stop_at_end();
    test_up_wrap_hold();
    test_load_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
